hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It drives `pipe_stall`, `ifid_FLUSH` and `idex_FLUSH` into the pipeline register bank, which sits alongside it. It does this from cache handshakes, hazard detection, multi-cycle EX occupancy and halt commit. It also keeps the halted state and two performance counters.

## Interface
Parameters:
- `MULT_LAT`, 4: total EX-stage cycles of a multiply. Legal range 1..16.

Ports:
- `CLK` in 1: clock. All state updates on the rising edge.
- `RST` in 1: reset. Synchronous, active-high.
- `ihit` in 1: instruction fetch data valid this cycle.
- `dhit` in 1: data memory access in MEM completes this cycle.
- `exmem_dREN`, `exmem_dWEN` in 1 each: MEM-stage instruction reads or writes data memory.
- `idex_dREN` in 1: EX-stage instruction is a load.
- `idex_rd` in 5: EX-stage destination register.
- `ifid_rs`, `ifid_rt` in 5 each: ID-stage source registers.
- `ifid_jump` in 1: ID-stage instruction is a jump.
- `ex_branch_taken` in 1: branch resolved taken in EX.
- `idex_mult` in 1: EX-stage instruction is a multiply.
- `memwb_halt` in 1: WB-stage instruction is HALT.
- `pipe_stall` out `pipe_stall_t`: one of NO_STALL, IFID_STALL, IDEX_STALL, EXMEM_STALL, FULL_STALL.
- `ifid_FLUSH`, `idex_FLUSH` out 1 each: zero the corresponding register on advance.
- `halt` out 1: core halted. Registered.
- `stall_cycles` out 32: count of cycles with `pipe_stall != NO_STALL` while not halted.
- `flush_count` out 32: count of cycles with `ifid_FLUSH=1`.

## Operation
- FSM states:
  - RUN.
  - MULT, with a 4-bit down-counter `mcnt`.
  - HALTED.
- Conditions:
  - `dwait` = (`exmem_dREN` | `exmem_dWEN`) & ~`dhit`.
  - `lduse` = `idex_dREN` & (`idex_rd` != 0) & (`idex_rd` == `ifid_rs` | `idex_rd` == `ifid_rt`).
- Stall resolution in RUN, by priority (first match wins):
  1. `dwait` → FULL_STALL.
  2. `idex_mult` & `MULT_LAT` > 1 → EXMEM_STALL. Next state MULT, with `mcnt` = `MULT_LAT`-2.
  3. `lduse` → IDEX_STALL.
  4. ~`ihit` → IFID_STALL.
  5. Otherwise → NO_STALL.
- MULT state:
  - `dwait` → FULL_STALL; `mcnt` is held.
  - Else if `mcnt` != 0 → EXMEM_STALL; `mcnt` decrements.
  - Else resolve as in RUN, with rule 2 suppressed. Next state RUN.
  - Net effect: exactly `MULT_LAT`-1 EXMEM_STALL cycles per multiply. FULL_STALL cycles do not count toward them.
- HALTED state:
  - `pipe_stall` = FULL_STALL, flushes 0, counters frozen, `halt`=1.
  - The state is left only by reset.
- Halt entry: `memwb_halt`=1 in a cycle whose resolved `pipe_stall` != FULL_STALL → next state HALTED. This takes priority over MULT entry.
- Flushes are qualified by the resolved `pipe_stall`:
  - When it is NO_STALL or IFID_STALL:
    - `ifid_FLUSH` = `ex_branch_taken` | `ifid_jump`.
    - `idex_FLUSH` = `ex_branch_taken`.
  - When it is IDEX_STALL, EXMEM_STALL or FULL_STALL: both flushes are 0. The source instruction is held, so its flush reasserts when the stall clears.
- Counters: 32-bit, wrap modulo 2^32, and increment at the clock edge closing the qualifying cycle.

## Timing
- `pipe_stall`, `ifid_FLUSH` and `idex_FLUSH` are combinational from the current inputs and the registered state. Inputs and outputs are in the same cycle, with no added latency.
- `halt` asserts the cycle after the `memwb_halt` commit cycle.
- Reset (`RST`=1 at an edge), from any state including mid-MULT or HALTED, gives next cycle:
  - state RUN, `mcnt`=0, `halt`=0;
  - `stall_cycles`=0, `flush_count`=0.
  - Combinational outputs follow the inputs from that cycle on.
- Simultaneous events:
  - `dwait` with `lduse`/~`ihit` → FULL_STALL only.
  - `idex_mult` with `lduse` → EXMEM_STALL.
  - `ex_branch_taken` with ~`ihit` → IFID_STALL, with both flushes 1.
- `MULT_LAT`=1: MULT is never entered and a multiply causes no stall.

## Test plan
- Reset, then `ihit`=1 and no other events → NO_STALL every cycle; `halt`=0; `stall_cycles` stays 0.
- `exmem_dREN`=1 with `dhit`=0 for 3 cycles, then `dhit`=1 → 3 cycles of FULL_STALL, then NO_STALL; `stall_cycles`=3.
- `idex_dREN`=1, `idex_rd`=5, `ifid_rt`=5 → IDEX_STALL. With `idex_rd`=0 → NO_STALL.
- `idex_mult`=1 with `MULT_LAT`=4 → exactly 3 EXMEM_STALL cycles. Inject `dwait` during the second of them → one FULL_STALL inserted, and still 3 EXMEM_STALL cycles in total.
- `ex_branch_taken`=1 with `ihit`=1 → NO_STALL, `ifid_FLUSH`=`idex_FLUSH`=1, `flush_count` +1. Same event with `dwait` → FULL_STALL, flushes 0.
- `memwb_halt`=1 → next cycle `halt`=1 and FULL_STALL permanently, counters frozen. Assert `RST` → RUN, `halt`=0, counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: resolves stall/flush for the 5-stage core from
// cache handshakes, load-use hazards, multi-cycle multiply occupancy and halt commit.
package hazard_ctrl_pkg;
  typedef enum logic [2:0] {
    NO_STALL    = 3'd0,
    IFID_STALL  = 3'd1,
    IDEX_STALL  = 3'd2,
    EXMEM_STALL = 3'd3,
    FULL_STALL  = 3'd4
  } pipe_stall_t;
endpackage

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        exmem_dREN,
  input  logic        exmem_dWEN,
  input  logic        idex_dREN,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ifid_jump,
  input  logic        ex_branch_taken,
  input  logic        idex_mult,
  input  logic        memwb_halt,
  output pipe_stall_t pipe_stall,
  output logic        ifid_FLUSH,
  output logic        idex_FLUSH,
  output logic        halt,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] MULT   = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  // The entry cycle is itself the first EXMEM stall, hence LAT-2 left to count.
  localparam logic [3:0] MCNT_INIT = (MULT_LAT > 1) ? 4'(MULT_LAT - 2) : 4'd0;

  logic [1:0] state, nstate;
  logic [3:0] mcnt, nmcnt;
  logic       dwait, lduse;

  assign dwait = (exmem_dREN | exmem_dWEN) & ~dhit;
  assign lduse = idex_dREN & (idex_rd != 5'd0) &
                 ((idex_rd == ifid_rs) | (idex_rd == ifid_rt));

  always_comb begin
    pipe_stall = NO_STALL;
    nstate     = state;
    nmcnt      = mcnt;
    ifid_FLUSH = 1'b0;
    idex_FLUSH = 1'b0;
    if (state == HALTED) begin
      pipe_stall = FULL_STALL;
    end else begin
      if (dwait) begin
        pipe_stall = FULL_STALL;
      end else if (state == MULT && mcnt != 4'd0) begin
        pipe_stall = EXMEM_STALL;
        nmcnt      = mcnt - 4'd1;
      end else if (state == RUN && idex_mult && MULT_LAT > 1) begin
        pipe_stall = EXMEM_STALL;
        nstate     = MULT;
        nmcnt      = MCNT_INIT;
      end else begin
        if (lduse)      pipe_stall = IDEX_STALL;
        else if (!ihit) pipe_stall = IFID_STALL;
        nstate = RUN;
      end

      // Held-instruction stalls suppress flushes; they reassert once the stall clears.
      if (pipe_stall == NO_STALL || pipe_stall == IFID_STALL) begin
        ifid_FLUSH = ex_branch_taken | ifid_jump;
        idex_FLUSH = ex_branch_taken;
      end

      if (memwb_halt && pipe_stall != FULL_STALL) begin
        nstate = HALTED;
        nmcnt  = 4'd0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= RUN;
      mcnt         <= 4'd0;
      halt         <= 1'b0;
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      state <= nstate;
      mcnt  <= nmcnt;
      halt  <= (nstate == HALTED);
      if (state != HALTED && pipe_stall != NO_STALL) stall_cycles <= stall_cycles + 32'd1;
      if (ifid_FLUSH) flush_count <= flush_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change on the falling edge, combinational
// outputs are checked 1ns later, registered state after the following rising edge.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic        CLK, RST;
  logic        ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN;
  logic [4:0]  idex_rd, ifid_rs, ifid_rt;
  logic        ifid_jump, ex_branch_taken, idex_mult, memwb_halt;
  pipe_stall_t pipe_stall;
  logic        ifid_FLUSH, idex_FLUSH, halt;
  logic [31:0] stall_cycles, flush_count;

  int tests = 0;
  int fails = 0;

  hazard_ctrl #(.MULT_LAT(4)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .idex_dREN(idex_dREN),
    .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_jump(ifid_jump),
    .ex_branch_taken(ex_branch_taken), .idex_mult(idex_mult), .memwb_halt(memwb_halt),
    .pipe_stall(pipe_stall), .ifid_FLUSH(ifid_FLUSH), .idex_FLUSH(idex_FLUSH),
    .halt(halt), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
    idex_dREN = 1'b0; idex_rd = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    ifid_jump = 1'b0; ex_branch_taken = 1'b0; idex_mult = 1'b0; memwb_halt = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++; if (halt !== 1'b0) begin fails++; $display("FAIL reset_halt got=%0b exp=0", halt); end
    tests++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
    tests++; if (flush_count !== 32'd0) begin fails++; $display("FAIL reset_flush_count got=%0d exp=0", flush_count); end
    tests++; if (pipe_stall !== NO_STALL) begin fails++; $display("FAIL reset_pipe_stall got=%0d exp=%0d", pipe_stall, NO_STALL); end
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (pipe_stall !== NO_STALL || ifid_FLUSH !== 1'b0 || idex_FLUSH !== 1'b0) begin
        fails++; $display("FAIL idle_c%0d stall=%0d fl=%0b%0b exp stall=0 fl=00", i, pipe_stall, ifid_FLUSH, idex_FLUSH);
      end
      tick();
    end
    tests++; if (stall_cycles !== 32'd0 || halt !== 1'b0) begin
      fails++; $display("FAIL idle_state stall_cycles=%0d halt=%0b exp 0 0", stall_cycles, halt);
    end
  endtask

  task automatic test_dwait();
    do_reset();
    exmem_dREN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (pipe_stall !== FULL_STALL) begin fails++; $display("FAIL dwait_c%0d got=%0d exp=%0d", i, pipe_stall, FULL_STALL); end
      tick();
    end
    dhit = 1'b1; #1;
    tests++; if (pipe_stall !== NO_STALL) begin fails++; $display("FAIL dwait_done got=%0d exp=%0d", pipe_stall, NO_STALL); end
    tick();
    tests++; if (stall_cycles !== 32'd3) begin fails++; $display("FAIL dwait_count got=%0d exp=3", stall_cycles); end
    // write miss combined with load-use and fetch miss still only FULL_STALL
    idle(); exmem_dWEN = 1'b1; ihit = 1'b0; idex_dREN = 1'b1; idex_rd = 5'd7; ifid_rs = 5'd7; #1;
    tests++; if (pipe_stall !== FULL_STALL) begin fails++; $display("FAIL dwait_prio got=%0d exp=%0d", pipe_stall, FULL_STALL); end
    tick(); idle();
  endtask

  task automatic test_lduse();
    do_reset();
    idex_dREN = 1'b1; idex_rd = 5'd5; ifid_rt = 5'd5; ifid_rs = 5'd1; #1;
    tests++; if (pipe_stall !== IDEX_STALL) begin fails++; $display("FAIL lduse_rt got=%0d exp=%0d", pipe_stall, IDEX_STALL); end
    tick();
    ifid_rt = 5'd2; ifid_rs = 5'd5; #1;
    tests++; if (pipe_stall !== IDEX_STALL) begin fails++; $display("FAIL lduse_rs got=%0d exp=%0d", pipe_stall, IDEX_STALL); end
    tick();
    idex_rd = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; #1;
    tests++; if (pipe_stall !== NO_STALL) begin fails++; $display("FAIL lduse_r0 got=%0d exp=%0d", pipe_stall, NO_STALL); end
    tick();
    idle(); ihit = 1'b0; #1;
    tests++; if (pipe_stall !== IFID_STALL) begin fails++; $display("FAIL imiss got=%0d exp=%0d", pipe_stall, IFID_STALL); end
    tick(); idle();
    tests++; if (stall_cycles !== 32'd3) begin fails++; $display("FAIL lduse_count got=%0d exp=3", stall_cycles); end
  endtask

  task automatic test_mult();
    pipe_stall_t exp_a [4];
    pipe_stall_t exp_b [5];
    exp_a = '{EXMEM_STALL, EXMEM_STALL, EXMEM_STALL, NO_STALL};
    exp_b = '{EXMEM_STALL, FULL_STALL, EXMEM_STALL, EXMEM_STALL, NO_STALL};
    do_reset();
    // entry cycle also carries a load-use hazard; multiply wins
    idex_mult = 1'b1; idex_dREN = 1'b1; idex_rd = 5'd3; ifid_rs = 5'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (pipe_stall !== exp_a[i]) begin fails++; $display("FAIL mult_c%0d got=%0d exp=%0d", i, pipe_stall, exp_a[i]); end
      if (i == 0) begin idex_dREN = 1'b0; idex_rd = 5'd0; ifid_rs = 5'd0; end
      tick();
    end
    idex_mult = 1'b0;
    tests++; if (stall_cycles !== 32'd3) begin fails++; $display("FAIL mult_count got=%0d exp=3", stall_cycles); end
    // data wait in the second EXMEM cycle does not consume a multiply cycle
    idex_mult = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exmem_dREN = (i == 1);
      #1;
      tests++; if (pipe_stall !== exp_b[i]) begin fails++; $display("FAIL multdw_c%0d got=%0d exp=%0d", i, pipe_stall, exp_b[i]); end
      tick();
    end
    idle();
    tests++; if (stall_cycles !== 32'd7) begin fails++; $display("FAIL multdw_count got=%0d exp=7", stall_cycles); end
  endtask

  task automatic test_flush();
    do_reset();
    ex_branch_taken = 1'b1; #1;
    tests++; if (pipe_stall !== NO_STALL || ifid_FLUSH !== 1'b1 || idex_FLUSH !== 1'b1) begin
      fails++; $display("FAIL br got stall=%0d fl=%0b%0b exp stall=0 fl=11", pipe_stall, ifid_FLUSH, idex_FLUSH);
    end
    tick();
    tests++; if (flush_count !== 32'd1) begin fails++; $display("FAIL br_count got=%0d exp=1", flush_count); end
    idle(); ifid_jump = 1'b1; #1;
    tests++; if (ifid_FLUSH !== 1'b1 || idex_FLUSH !== 1'b0) begin fails++; $display("FAIL jump got fl=%0b%0b exp fl=10", ifid_FLUSH, idex_FLUSH); end
    tick();
    idle(); ex_branch_taken = 1'b1; ihit = 1'b0; #1;
    tests++; if (pipe_stall !== IFID_STALL || ifid_FLUSH !== 1'b1 || idex_FLUSH !== 1'b1) begin
      fails++; $display("FAIL br_imiss got stall=%0d fl=%0b%0b exp stall=1 fl=11", pipe_stall, ifid_FLUSH, idex_FLUSH);
    end
    tick();
    idle(); ex_branch_taken = 1'b1; exmem_dREN = 1'b1; #1;
    tests++; if (pipe_stall !== FULL_STALL || ifid_FLUSH !== 1'b0 || idex_FLUSH !== 1'b0) begin
      fails++; $display("FAIL br_dwait got stall=%0d fl=%0b%0b exp stall=4 fl=00", pipe_stall, ifid_FLUSH, idex_FLUSH);
    end
    tick();
    idle(); ex_branch_taken = 1'b1; idex_dREN = 1'b1; idex_rd = 5'd9; ifid_rt = 5'd9; #1;
    tests++; if (pipe_stall !== IDEX_STALL || ifid_FLUSH !== 1'b0 || idex_FLUSH !== 1'b0) begin
      fails++; $display("FAIL br_lduse got stall=%0d fl=%0b%0b exp stall=2 fl=00", pipe_stall, ifid_FLUSH, idex_FLUSH);
    end
    tick(); idle();
    tests++; if (flush_count !== 32'd3) begin fails++; $display("FAIL flush_count got=%0d exp=3", flush_count); end
  endtask

  task automatic test_halt();
    do_reset();
    // halt commit blocked by a data wait
    memwb_halt = 1'b1; exmem_dREN = 1'b1; tick(); idle(); #1;
    tests++; if (halt !== 1'b0 || pipe_stall !== NO_STALL) begin fails++; $display("FAIL halt_blocked got halt=%0b stall=%0d exp 0 0", halt, pipe_stall); end
    ihit = 1'b0; tick();
    // halt commit coinciding with a multiply entry goes straight to HALTED
    memwb_halt = 1'b1; idex_mult = 1'b1; #1;
    tests++; if (halt !== 1'b0 || pipe_stall !== EXMEM_STALL) begin fails++; $display("FAIL halt_commit got halt=%0b stall=%0d exp 0 3", halt, pipe_stall); end
    tick(); idle(); ex_branch_taken = 1'b1; #1;
    tests++; if (halt !== 1'b1 || pipe_stall !== FULL_STALL || ifid_FLUSH !== 1'b0 || idex_FLUSH !== 1'b0) begin
      fails++; $display("FAIL halted got halt=%0b stall=%0d fl=%0b%0b exp 1 4 00", halt, pipe_stall, ifid_FLUSH, idex_FLUSH);
    end
    for (int i = 0; i < 5; i++) tick();
    #1;
    tests++; if (halt !== 1'b1 || pipe_stall !== FULL_STALL) begin fails++; $display("FAIL halted_hold got halt=%0b stall=%0d exp 1 4", halt, pipe_stall); end
    tests++; if (stall_cycles !== 32'd3 || flush_count !== 32'd0) begin
      fails++; $display("FAIL halted_frozen got stall_cycles=%0d flush_count=%0d exp 3 0", stall_cycles, flush_count);
    end
    do_reset(); #1;
    tests++; if (halt !== 1'b0 || pipe_stall !== NO_STALL || stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      fails++; $display("FAIL halt_reset got halt=%0b stall=%0d sc=%0d fc=%0d exp 0 0 0 0", halt, pipe_stall, stall_cycles, flush_count);
    end
  endtask

  initial begin
    RST = 1'b1;
    idle();
    @(negedge CLK);
    test_reset();
    test_idle();
    test_dwait();
    test_lduse();
    test_mult();
    test_flush();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
